// File: rtl/udp_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// udp_tx_arbiter_if
//   Bundles the packet-source side and the UDP-core side of the transmit
//   arbiter into one interface.
//
//   master modport : the arbiter (drives strobes, grants and the UDP request)
//   slave  modport : the environment (packet sources + udp_ip_mac_top)
//
//   Source side  : src_req, src_len, src_data  -> arbiter
//                  src_rd_en, src_grant, src_done, src_err <- arbiter
//   UDP side     : app_data_request, app_data_length,
//                  app_data_in_valid, app_data_in  <- arbiter
//                  udp_send_ack, mac_send_end      -> arbiter
//   src_len slice i is [16*i+15:16*i]; src_data slice i is [8*i+7:8*i].
// -----------------------------------------------------------------------------
interface udp_tx_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]    src_req;
  logic [16*N_SRC-1:0] src_len;
  logic [8*N_SRC-1:0]  src_data;
  logic [N_SRC-1:0]    src_rd_en;
  logic [N_SRC-1:0]    src_grant;
  logic [N_SRC-1:0]    src_done;
  logic [N_SRC-1:0]    src_err;

  logic                app_data_request;
  logic [15:0]         app_data_length;
  logic                udp_send_ack;
  logic                app_data_in_valid;
  logic [7:0]          app_data_in;
  logic                mac_send_end;

  modport master (
    input  src_req, src_len, src_data, udp_send_ack, mac_send_end,
    output src_rd_en, src_grant, src_done, src_err,
           app_data_request, app_data_length, app_data_in_valid, app_data_in
  );

  modport slave (
    output src_req, src_len, src_data, udp_send_ack, mac_send_end,
    input  src_rd_en, src_grant, src_done, src_err,
           app_data_request, app_data_length, app_data_in_valid, app_data_in
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// udp_tx_arbiter
//   Shares the single UDP transmit path of udp_ip_mac_top among N_SRC packet
//   sources. Round-robin selection, then the handshake
//   app_data_request -> udp_send_ack -> byte stream -> mac_send_end,
//   followed by an inter-packet gap of IFG_CYCLES before re-arbitration.
//   Everything lives in the rgmii_clk domain.
//
// Ports
//   rgmii_clk : clock, rising edge
//   rstn      : asynchronous active-low reset
//   bus       : udp_tx_arbiter_if.master (sources + UDP core handshake)
//   busy      : high whenever the controller is not in IDLE
//
// Timing of the byte path
//   src_rd_en[i] high in cycle c -> source drives src_data in c+1 ->
//   registered here -> app_data_in_valid / app_data_in in c+2.
// -----------------------------------------------------------------------------
module udp_tx_arbiter #(
  parameter int N_SRC       = 4,
  parameter int MAX_LEN     = 1472,
  parameter int ACK_TIMEOUT = 1_250_000,
  parameter int IFG_CYCLES  = 16
) (
  input  logic             rgmii_clk,
  input  logic             rstn,
  udp_tx_arbiter_if.master bus,
  output logic             busy
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [N_SRC-1:0] ONE_HOT_0 = N_SRC'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REQ,
    S_STREAM,
    S_WAIT_END,
    S_GAP
  } state_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;         // round-robin start point
  logic [IW-1:0]    idx_q, idx_d;       // index of the served source
  logic [15:0]      len_q, len_d;       // latched length, also app_data_length
  logic [15:0]      cnt_q, cnt_d;       // bytes pulled so far
  logic [31:0]      timer_q, timer_d;   // cleared on every state entry
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [N_SRC-1:0] rd_en_q, rd_en_d;
  logic [N_SRC-1:0] done_q, done_d;
  logic [N_SRC-1:0] err_q, err_d;
  logic             req_q, req_d;       // app_data_request
  logic             pull_q, pull_d;     // source is driving a byte this cycle
  logic             valid_q, valid_d;   // app_data_in_valid
  logic [7:0]       data_q, data_d;     // app_data_in
  logic             busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // Round-robin selection: lowest requester at or above rr_q, otherwise the
  // lowest requester overall (wrap-around).
  // ---------------------------------------------------------------------------
  logic          sel_any;
  logic          sel_hi;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic [IW-1:0] sel_idx;
  logic [15:0]   sel_len;
  logic          sel_len_bad;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    sel_any = 1'b0;
    sel_hi  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    // Walk downward so the last hit is the lowest qualifying index.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.src_req[i]) begin
        sel_any = 1'b1;
        lo_idx  = IW'(i);
        if (IW'(i) >= rr_q) begin
          sel_hi = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    sel_idx = sel_hi ? hi_idx : lo_idx;

    sel_len = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel_idx == IW'(i)) sel_len = bus.src_len[16*i +: 16];
    end
    sel_len_bad = (sel_len == 16'd0) || (32'(sel_len) > 32'(MAX_LEN));
  end

  // Byte from the served source; only meaningful while pull_q is high.
  logic [7:0] data_sel;

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (idx_q == IW'(i)) data_sel = bus.src_data[8*i +: 8];
    end
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(N_SRC - 1)) ? '0 : i + IW'(1);
  endfunction

  logic timer_ack_expired;
  logic timer_gap_done;
  logic stream_drained;

  assign timer_ack_expired = (timer_q == 32'(ACK_TIMEOUT - 1));
  assign timer_gap_done    = (timer_q == 32'(IFG_CYCLES - 1));
  // All bytes pulled, none in flight, and the last one is on app_data_in now.
  assign stream_drained    = (cnt_q == len_q) && !pull_q && valid_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rd_en_d = rd_en_q;
    done_d  = '0;
    err_d   = '0;
    req_d   = req_q;
    pull_d  = |rd_en_q;
    valid_d = pull_q;
    data_d  = pull_q ? data_sel : 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (bus.src_req != '0) state_d = S_ARB;
      end

      S_ARB: begin
        if (!sel_any) begin
          // Request withdrawn before arbitration; nothing to serve.
          state_d = S_IDLE;
        end else begin
          idx_d = sel_idx;
          len_d = sel_len;
          if (sel_len_bad) begin
            err_d   = ONE_HOT_0 << sel_idx;
            grant_d = '0;
            rr_d    = wrap_inc(sel_idx);
            state_d = S_GAP;
          end else begin
            grant_d = ONE_HOT_0 << sel_idx;
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (bus.udp_send_ack) begin
          req_d   = 1'b0;
          rd_en_d = grant_q;
          cnt_d   = '0;
          state_d = S_STREAM;
        end else if (timer_ack_expired) begin
          req_d   = 1'b0;
          err_d   = grant_q;
          grant_d = '0;
          rr_d    = wrap_inc(idx_q);
          state_d = S_GAP;
        end
      end

      S_STREAM: begin
        if (rd_en_q != '0) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == len_q) rd_en_d = '0;
        end
        if (stream_drained) state_d = S_WAIT_END;
      end

      S_WAIT_END: begin
        // mac_send_end is checked first so done wins over a coincident timeout.
        if (bus.mac_send_end) begin
          done_d  = grant_q;
          grant_d = '0;
          rr_d    = wrap_inc(idx_q);
          state_d = S_GAP;
        end else if (timer_ack_expired) begin
          err_d   = grant_q;
          grant_d = '0;
          rr_d    = wrap_inc(idx_q);
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (timer_gap_done) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    timer_d = (state_d != state_q) ? 32'd0 : timer_q + 32'd1;
    busy_d  = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      grant_q <= '0;
      rd_en_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      req_q   <= 1'b0;
      pull_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge; blocking here would chain registers within one cycle.
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      pull_q  <= pull_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.src_rd_en         = rd_en_q;
  assign bus.src_grant         = grant_q;
  assign bus.src_done          = done_q;
  assign bus.src_err           = err_q;
  assign bus.app_data_request  = req_q;
  assign bus.app_data_length   = len_q;
  assign bus.app_data_in_valid = valid_q;
  assign bus.app_data_in       = data_q;
  assign busy                  = busy_q;

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit path of udp_ip_mac_top among N independent packet sources, e.g. a sensor stream, a command-reply engine and a status beacon.
- Round-robin arbitration; the block sequences the app_data_request → udp_send_ack → byte-stream → mac_send_end handshake.
- Pulls payload bytes from the granted source and enforces an inter-packet gap.
- Sits between the application sources and udp_ip_mac_top, in the rgmii_clk domain.

Parameters:
- N_SRC, 4, number of requesters (2..8).
- MAX_LEN, 1472, maximum UDP payload bytes accepted.
- ACK_TIMEOUT, 1_250_000, cycles to wait for udp_send_ack or mac_send_end before abort (10 ms at 125 MHz).
- IFG_CYCLES, 16, idle cycles inserted after each packet before the next arbitration.

Ports:
- rgmii_clk  in  1  single clock, all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- src_req  in  N_SRC  per-source packet request, level, held until src_done or src_err.
- src_len  in  16*N_SRC  per-source payload length; slice i = [16*i+15:16*i]; stable while src_req[i] is high.
- src_data  in  8*N_SRC  per-source byte; driven the cycle after src_rd_en[i].
- src_rd_en  out  N_SRC  byte pull strobe, only to the granted source.
- src_grant  out  N_SRC  one-hot grant, high from ARB exit to packet completion.
- src_done  out  N_SRC  one-cycle pulse: packet fully sent (mac_send_end seen).
- src_err  out  N_SRC  one-cycle pulse: bad length or timeout.
- app_data_request  out  1  request to the UDP core, level.
- app_data_length  out  16  latched length of the granted packet.
- udp_send_ack  in  1  UDP core ready for payload.
- app_data_in_valid  out  1  payload byte strobe.
- app_data_in  out  8  payload byte.
- mac_send_end  in  1  frame transmission finished pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; round-robin pointer rr = 0; state IDLE.
- IDLE: when src_req ≠ 0, go to ARB next cycle.
- ARB, one cycle:
  - Select the first requesting index at or after rr, modulo N_SRC.
  - Latch its length into len_q and app_data_length; set src_grant.
  - If len = 0 or len > MAX_LEN: pulse src_err[i], clear grant, set rr = i+1 mod N_SRC, go to GAP. No downstream request is issued.
  - Otherwise go to REQ.
- REQ:
  - app_data_request = 1; timer counts.
  - On udp_send_ack: drop app_data_request the same cycle it is sampled, go to STREAM.
  - If the timer reaches ACK_TIMEOUT: src_err, go to GAP.
- STREAM:
  - Assert src_rd_en[i] for exactly len_q consecutive cycles.
  - Byte counter is 16 bits, increments per rd_en.
  - Source drives src_data one cycle after rd_en. The block registers it, so app_data_in_valid/app_data_in appear 2 cycles after the matching rd_en.
  - Exactly len_q valid bytes, contiguous, in source order.
  - After the last valid byte, go to WAIT_END.
- WAIT_END:
  - On mac_send_end: pulse src_done[i], go to GAP.
  - If the timer reaches ACK_TIMEOUT: src_err, go to GAP.
  - A mac_send_end outside WAIT_END is ignored.
- GAP:
  - Grant cleared.
  - rr = served index + 1, mod N_SRC. rr advances on done, err or timeout alike.
  - Count IFG_CYCLES, then go to IDLE.
- Fairness: a continuously requesting source waits at most N_SRC−1 packets.
- Changes to src_req/src_len after ARB are ignored until GAP.
- Simultaneous events:
  - udp_send_ack in the same cycle the timer expires: ack wins.
  - mac_send_end in the same cycle as timeout: done wins.
- Dropping src_req[i] mid-packet is ignored; the packet completes.
- Timer clears on every state entry; it is 32 bits.
- Reset mid-operation: outputs return to 0 immediately (asynchronous). No done/err pulse is issued for the aborted packet.

Test Plan:
- Single source: N_SRC=4, src_req=4'b0010, len=5, bytes A0..A4, ack 3 cycles after request, mac_send_end 20 cycles later → grant=0010, 5 rd_en, app_data_in_valid bytes A0..A4, app_data_length=5, src_done[1] pulse, 16-cycle gap, then IDLE.
- Round robin: all four sources request continuously with len=2 → service order 0,1,2,3,0; exactly 2 bytes and one done per packet; no grant overlap.
- Bad length: src0 len=0, src1 len=1473 → src_err[0] then src_err[1], app_data_request never asserted, rr advances to 2.
- Ack timeout, ACK_TIMEOUT=100: no udp_send_ack → src_err pulse at request+100 cycles, request dropped, next source served after the gap.
- Boundary length: len=1472 → exactly 1472 contiguous valid bytes, last byte correct, done on mac_send_end.
- Reset in STREAM after byte 3 of 10 → all outputs 0 asynchronously, rr=0. After release with req still high, the packet restarts from byte 0.
